// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: 2-bit saturating counter encoding and
// the counter training function used by the gshare PHT.
package bpu_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RESET = WNT;

  // Move one step toward the observed outcome, sticking at either end.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gshare_param_pht_sat.sv
// Pattern history table of 2-bit saturating counters: one combinational read
// port for fetch, one clocked read-modify-write training port.
module pht_sat
  import bpu_pkg::*;
#(
  parameter int IDX_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output ctr_t                 rd_ctr,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  // Every entry must clear on the asynchronous reset, so this stays in flops.
  ctr_t ctr_reg [DEPTH];

  assign rd_ctr = ctr_reg[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_reg[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr_reg[wr_idx] <= sat_update(ctr_reg[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_param.sv
// Gshare direction predictor: PC XOR global history indexes a counter table.
// Optional statistics counters are enabled with macro GSHARE_STATS_EN.
module gshare_param
  import bpu_pkg::*;
#(
  parameter int PC_WIDTH  = 64,
  parameter int IDX_WIDTH = 10,
  parameter int GHR_WIDTH = 10
) (
  input  logic                 in_Clk,
  input  logic                 in_Rst,
  input  logic                 in_pred_valid,
  input  logic [PC_WIDTH-1:0]  in_pred_PC,
  output logic                 out_prediction,
  output logic [IDX_WIDTH-1:0] out_pred_index,
  output logic [GHR_WIDTH-1:0] out_pred_ghr,
  input  logic                 in_upd_valid,
  input  logic [IDX_WIDTH-1:0] in_upd_index,
  input  logic [GHR_WIDTH-1:0] in_upd_ghr,
  input  logic                 in_upd_taken,
  input  logic                 in_upd_mispredict
`ifdef GSHARE_STATS_EN
  ,
  output logic [31:0]          out_stat_updates,
  output logic [31:0]          out_stat_mispred
`endif
);

  logic [GHR_WIDTH-1:0] ghr_reg;
  logic [GHR_WIDTH-1:0] ghr_next;
  logic [GHR_WIDTH-1:0] shift_src;
  logic [GHR_WIDTH-1:0] shifted;
  logic [IDX_WIDTH-1:0] pred_idx;
  logic                 shift_bit;
  logic                 repair;
  ctr_t                 pred_ctr;

  logic unused_pc;
  assign unused_pc = ^{in_pred_PC[1:0], in_pred_PC[PC_WIDTH-1:IDX_WIDTH+2]};

  assign pred_idx       = in_pred_PC[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_reg);
  assign out_prediction = pred_ctr[1];
  assign out_pred_index = pred_idx;
  assign out_pred_ghr   = ghr_reg;

  // A mispredict repair rebuilds history from the checkpoint and wins over
  // the speculative shift of the current fetch.
  assign repair    = in_upd_valid & in_upd_mispredict;
  assign shift_src = repair ? in_upd_ghr : ghr_reg;
  assign shift_bit = repair ? in_upd_taken : out_prediction;

  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign shifted = shift_bit;
    end else begin : g_ghr_many
      assign shifted = {shift_src[GHR_WIDTH-2:0], shift_bit};
    end
  endgenerate

  always_comb begin
    ghr_next = ghr_reg;
    if (repair || in_pred_valid) ghr_next = shifted;
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) ghr_reg <= '0;
    else        ghr_reg <= ghr_next;
  end

  pht_sat #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pht (
    .clk      (in_Clk),
    .rst      (in_Rst),
    .rd_idx   (pred_idx),
    .rd_ctr   (pred_ctr),
    .wr_en    (in_upd_valid),
    .wr_idx   (in_upd_index),
    .wr_taken (in_upd_taken)
  );

`ifdef GSHARE_STATS_EN
  logic [31:0] upd_cnt_reg;
  logic [31:0] mis_cnt_reg;

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      upd_cnt_reg <= '0;
      mis_cnt_reg <= '0;
    end else begin
      if (in_upd_valid && (upd_cnt_reg != '1)) upd_cnt_reg <= upd_cnt_reg + 32'd1;
      if (repair && (mis_cnt_reg != '1))       mis_cnt_reg <= mis_cnt_reg + 32'd1;
    end
  end

  assign out_stat_updates = upd_cnt_reg;
  assign out_stat_mispred = mis_cnt_reg;
`endif

endmodule

// File: tb/tb_gshare_param.sv
// Self-checking bench for gshare_param: a reference model pushes expected
// fetch outputs to a queue, which are popped and compared each cycle.
module tb_gshare_param;

  localparam int PW = 64;
  localparam int IW = 10;
  localparam int GW = 10;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [PW-1:0] pred_pc;
  logic          prediction;
  logic [IW-1:0] pred_index;
  logic [GW-1:0] pred_ghr;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic [GW-1:0] upd_ghr;
  logic          upd_taken;
  logic          upd_mispredict;
`ifdef GSHARE_STATS_EN
  logic [31:0]   stat_updates;
  logic [31:0]   stat_mispred;
`endif

  always #5 clk = ~clk;

  gshare_param #(.PC_WIDTH(PW), .IDX_WIDTH(IW), .GHR_WIDTH(GW)) dut (
    .in_Clk            (clk),
    .in_Rst            (rst),
    .in_pred_valid     (pred_valid),
    .in_pred_PC        (pred_pc),
    .out_prediction    (prediction),
    .out_pred_index    (pred_index),
    .out_pred_ghr      (pred_ghr),
    .in_upd_valid      (upd_valid),
    .in_upd_index      (upd_index),
    .in_upd_ghr        (upd_ghr),
    .in_upd_taken      (upd_taken),
    .in_upd_mispredict (upd_mispredict)
`ifdef GSHARE_STATS_EN
    ,
    .out_stat_updates  (stat_updates),
    .out_stat_mispred  (stat_mispred)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          pred;
    logic [IW-1:0] idx;
    logic [GW-1:0] ghr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Reference model state and the update pending for the next clock edge.
  logic [1:0]    m_pht [DEPTH];
  logic [GW-1:0] m_ghr;
  logic          p_uv;
  logic          p_ut;
  logic [IW-1:0] p_ui;
  logic [GW-1:0] p_ghr;

  function automatic logic [1:0] m_train(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic clear_inputs();
    pred_valid = 0; pred_pc = '0; upd_valid = 0; upd_index = '0;
    upd_ghr = '0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 2'b01;
    m_ghr = '0;
    p_uv = 0; p_ut = 0; p_ui = '0; p_ghr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    clear_inputs();
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 0;
  endtask

  // Drive one cycle of stimulus and queue the expected combinational outputs.
  task automatic apply(input logic pv, input logic [PW-1:0] pc, input logic uv,
                       input logic [IW-1:0] ui, input logic [GW-1:0] ug,
                       input logic ut, input logic um);
    logic [IW-1:0] idx;
    logic          pr;
    pred_valid = pv; pred_pc = pc; upd_valid = uv; upd_index = ui;
    upd_ghr = ug; upd_taken = ut; upd_mispredict = um;
    idx = pc[IW+1:2] ^ m_ghr;
    pr  = m_pht[idx][1];
    exp_q.push_back('{pr, idx, m_ghr});
    p_uv = uv; p_ui = ui; p_ut = ut;
    if (uv && um)  p_ghr = {ug[GW-2:0], ut};
    else if (pv)   p_ghr = {m_ghr[GW-2:0], pr};
    else           p_ghr = m_ghr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (p_uv) m_pht[p_ui] = m_train(m_pht[p_ui], p_ut);
    m_ghr = p_ghr;
    p_uv = 0;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1, 64'h100, 1, 10'h40, '0, 1, 0);
      e = exp_q.pop_front();
      checks++;
      if ({prediction, pred_index, pred_ghr} !== e)
        $display("FAIL pre_reset_%0d got %h want %h", k, {prediction, pred_index, pred_ghr}, e);
      tick();
    end
    #3 rst = 1;
    pred_pc = 64'hABC;
    #1;
    checks++;
    if ({prediction, pred_ghr} !== {1'b0, 10'h000}) begin
      errors++;
      $display("FAIL reset_outputs got pred=%b ghr=%h want pred=0 ghr=000", prediction, pred_ghr);
    end
    checks++;
    if (pred_index !== 10'h2AF) begin
      errors++;
      $display("FAIL reset_index got %h want 2af", pred_index);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.u_pht.ctr_reg[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_backdoor got %0d entries not WNT want 0", bad);
    end
    @(negedge clk);
    rst = 0;
    clear_inputs();
    model_reset();
    exp_q.delete();
  endtask

  task automatic test_training();
    logic [1:0] want_ctr [3];
    want_ctr = '{2'b10, 2'b11, 2'b11};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(0, 64'h100, 1, 10'h40, '0, 1, 0);
      e = exp_q.pop_front();
      checks++;
      if ({prediction, pred_index, pred_ghr} !== e) begin
        errors++;
        $display("FAIL train_%0d got %h want %h", k, {prediction, pred_index, pred_ghr}, e);
      end
      tick();
      checks++;
      if (dut.u_pht.ctr_reg[10'h40] !== want_ctr[k]) begin
        errors++;
        $display("FAIL train_ctr_%0d got %b want %b", k, dut.u_pht.ctr_reg[10'h40], want_ctr[k]);
      end
    end
    apply(0, 64'h100, 0, '0, '0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if ({prediction, pred_index, pred_ghr} !== {1'b1, 10'h040, 10'h000}) begin
      errors++;
      $display("FAIL train_final got %h want %h", {prediction, pred_index, pred_ghr}, {1'b1, 10'h040, 10'h000});
    end
    tick();
  endtask

  task automatic test_spec_shift();
    logic [GW-1:0] want_ghr [3];
    want_ghr = '{10'h000, 10'h001, 10'h003};
    do_reset();
    apply(0, 0, 1, 10'h40, '0, 1, 0); void'(exp_q.pop_front()); tick();
    apply(0, 0, 1, 10'h41, '0, 1, 0); void'(exp_q.pop_front()); tick();
    apply(0, 0, 1, 10'h43, '0, 1, 0); void'(exp_q.pop_front()); tick();
    for (int k = 0; k < 3; k++) begin
      apply(1, 64'h100, 0, '0, '0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({prediction, pred_index, pred_ghr} !== e ||
          prediction !== 1'b1 || pred_ghr !== want_ghr[k]) begin
        errors++;
        $display("FAIL spec_shift_%0d got %h want %h", k, {prediction, pred_index, pred_ghr}, e);
      end
      tick();
    end
    apply(1, 64'h100, 0, '0, '0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (pred_index !== 10'h047 || pred_ghr !== 10'h007) begin
      errors++;
      $display("FAIL spec_shift_4th got idx=%h ghr=%h want idx=047 ghr=007", pred_index, pred_ghr);
    end
    tick();
  endtask

  task automatic test_repair();
    do_reset();
    apply(0, 0, 1, 10'h40, '0, 1, 0); void'(exp_q.pop_front()); tick();
    apply(1, 64'h100, 1, 10'h200, 10'h005, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if ({prediction, pred_index, pred_ghr} !== e || prediction !== 1'b1) begin
      errors++;
      $display("FAIL repair_cycle got %h want %h", {prediction, pred_index, pred_ghr}, e);
    end
    tick();
    apply(0, 64'h100, 1, 10'h201, 10'h3FF, 1, 1);
    e = exp_q.pop_front();
    checks++;
    if (pred_ghr !== 10'h00A || pred_index !== 10'h04A) begin
      errors++;
      $display("FAIL repair_ghr got ghr=%h idx=%h want ghr=00a idx=04a", pred_ghr, pred_index);
    end
    tick();
    apply(0, 64'h100, 1, 10'h202, 10'h001, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (pred_ghr !== 10'h3FF) begin
      errors++;
      $display("FAIL repair_taken got ghr=%h want 3ff", pred_ghr);
    end
    tick();
    apply(0, 64'h100, 0, '0, '0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (pred_ghr !== 10'h3FF) begin
      errors++;
      $display("FAIL no_repair_hold got ghr=%h want 3ff", pred_ghr);
    end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    apply(1, 64'h100, 1, 10'h40, '0, 1, 0);
    e = exp_q.pop_front();
    checks++;
    if (prediction !== 1'b0 || {prediction, pred_index, pred_ghr} !== e) begin
      errors++;
      $display("FAIL collide_same got %h want %h", {prediction, pred_index, pred_ghr}, e);
    end
    tick();
    apply(0, 64'h100, 0, '0, '0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (prediction !== 1'b1 || pred_index !== 10'h040) begin
      errors++;
      $display("FAIL collide_next got pred=%b idx=%h want pred=1 idx=040", prediction, pred_index);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] pc;
    logic [IW-1:0] ui;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      pc = 64'h100 + 64'($urandom_range(0, 7)) * 64'd4;
      ui = 10'h40 ^ 10'($urandom_range(0, 15));
      apply(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), ui,
            10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      e = exp_q.pop_front();
      checks++;
      if ({prediction, pred_index, pred_ghr} !== e) begin
        errors++;
        $display("FAIL b2b_%0d got %h want %h", k, {prediction, pred_index, pred_ghr}, e);
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
  endtask

`ifdef GSHARE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(1'(k % 2), 64'h100, 1, 10'(k), 10'(k), 1'(k % 2), (k % 3) == 0);
      void'(exp_q.pop_front());
      tick();
    end
    apply(1, 64'h100, 0, '0, '0, 0, 1);
    void'(exp_q.pop_front());
    tick();
    checks++;
    if (stat_updates !== 32'd10 || stat_mispred !== 32'd4) begin
      errors++;
      $display("FAIL stats_count got %0d/%0d want 10/4", stat_updates, stat_mispred);
    end
    do_reset();
    checks++;
    if (stat_updates !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset got %0d/%0d want 0/0", stat_updates, stat_mispred);
    end
  endtask
`endif

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_training();
    test_spec_shift();
    test_repair();
    test_collision();
    test_back_to_back();
`ifdef GSHARE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_param.md
Name: gshare_param

Overview:
- Next-generation gshare direction predictor for the RV64IF BPU.
- Indexes a table of 2-bit saturating counters with PC bits XOR the global history register (GHR).
- Fetch-time prediction port with speculative history update; separate execute-time resolve port that trains counters and repairs history on mispredict.
- Sits between fetch PC generation and the branch resolution unit; prediction is combinational from registered state.

Parameters:
- PC_WIDTH, 64, width of in_pred_PC; bits [1:0] dropped before hashing.
- IDX_WIDTH, 10, PHT index width; PHT depth = 2**IDX_WIDTH.
- GHR_WIDTH, 10, history length; must be <= IDX_WIDTH; history is zero-extended to IDX_WIDTH before XOR.

Ports:
- in_Clk  in  1  clock, rising edge.
- in_Rst  in  1  asynchronous, active-high reset.
- in_pred_valid  in  1  fetch requests a prediction this cycle.
- in_pred_PC  in  PC_WIDTH  branch PC.
- out_prediction  out  1  1 = taken (counter MSB).
- out_pred_index  out  IDX_WIDTH  PHT index used; carried down the pipe.
- out_pred_ghr  out  GHR_WIDTH  GHR before this prediction (checkpoint).
- in_upd_valid  in  1  resolved branch this cycle.
- in_upd_index  in  IDX_WIDTH  index returned from the prediction.
- in_upd_ghr  in  GHR_WIDTH  checkpoint returned from the prediction.
- in_upd_taken  in  1  actual outcome.
- in_upd_mispredict  in  1  predicted direction was wrong.

Behaviour:
- Reset (async, any time, including mid-operation): every counter = 2'b01 (weakly not-taken), GHR = 0. Outputs are then out_prediction = 0, out_pred_index = PC hash XOR 0, out_pred_ghr = 0.
- Index = in_pred_PC[IDX_WIDTH+1:2] XOR {zero-extended GHR}. out_* valid in the same cycle as in_pred_valid (0-cycle latency). Outputs are driven regardless of valid.
- Speculative history: on in_pred_valid with no update-path repair, next GHR = {GHR[GHR_WIDTH-2:0], out_prediction}.
- Repair: on in_upd_valid && in_upd_mispredict, next GHR = {in_upd_ghr[GHR_WIDTH-2:0], in_upd_taken}. Repair has priority over a same-cycle speculative shift, which is discarded.
- Training: on in_upd_valid, counter[in_upd_index] increments if taken (saturate at 3), decrements if not taken (saturate at 0). This happens whether or not the branch mispredicted.
- Same-cycle read and write of one index: the prediction reads the pre-update value. The write lands at the clock edge.
- No valid on either port: all state holds.
- GHR_WIDTH == 1: the shift degenerates to GHR = new bit.

Optional Feature:
- Macro GSHARE_STATS_EN. When defined, adds two outputs:
  - out_stat_updates (32b): count of in_upd_valid cycles.
  - out_stat_mispred (32b): count of in_upd_valid && in_upd_mispredict cycles.
- Both counters saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package bpu_pkg holds:
  - counter encoding constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - CTR_RESET = WNT;
  - function sat_update(ctr, taken).
- One sub-module, pht_sat: parametrised IDX_WIDTH counter array with one async read port and one sync write port, reset to CTR_RESET.
- The GHR and hashing live in gshare_param.

Test Plan:
- Reset: assert in_Rst mid-run, then release. Any PC -> out_prediction=0, out_pred_ghr=0. Every index reads WNT via backdoor.
- Training saturation: PC=0x100, GHR=0. Issue 3 updates at its index with taken=1 -> counter 01→10→11→11. Prediction flips to 1 after the first update.
- Speculative shift: 3 predictions that all predict 1 -> GHR = 0b111. out_pred_index on the 4th request = PC[11:2] ^ 0x007.
- Repair priority: same cycle, pred_valid=1 and update with mispredict=1, in_upd_ghr=0x005, taken=0 -> next GHR = 0x00A. The speculative bit is discarded.
- Read/write collision: predict and update on the same index, counter=01, taken=1 -> out_prediction=0 this cycle, 1 next cycle.
- GSHARE_STATS_EN: 10 updates with 4 mispredicts -> out_stat_updates=10, out_stat_mispred=4. Both return to 0 on reset.
